// File: rtl/f_axil_monitor.sv
// Passive AXI-lite monitor: outstanding counters, stall-stability checks, sticky error flags.
// Defining F_AXIL_MONITOR_TIMEOUT_EN adds B/R response timeout detection (flag bits 10/11).
module f_axil_monitor #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int OUTSTAND_MAX   = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ADDR_WIDTH-1:0]         m_axil_awaddr,
  input  logic [2:0]                    m_axil_awprot,
  input  logic                          m_axil_awvalid,
  input  logic                          m_axil_awready,
  input  logic [DATA_WIDTH-1:0]         m_axil_wdata,
  input  logic [STRB_WIDTH-1:0]         m_axil_wstrb,
  input  logic                          m_axil_wvalid,
  input  logic                          m_axil_wready,
  input  logic [1:0]                    m_axil_bresp,
  input  logic                          m_axil_bvalid,
  input  logic                          m_axil_bready,
  input  logic [ADDR_WIDTH-1:0]         m_axil_araddr,
  input  logic [2:0]                    m_axil_arprot,
  input  logic                          m_axil_arvalid,
  input  logic                          m_axil_arready,
  input  logic [DATA_WIDTH-1:0]         m_axil_rdata,
  input  logic [1:0]                    m_axil_rresp,
  input  logic                          m_axil_rvalid,
  input  logic                          m_axil_rready,
  input  logic                          err_clear,
  output logic [$clog2(OUTSTAND_MAX):0] aw_cnt,
  output logic [$clog2(OUTSTAND_MAX):0] w_cnt,
  output logic [$clog2(OUTSTAND_MAX):0] ar_cnt,
  output logic [11:0]                   err_flags,
  output logic                          err_pulse,
  output logic [3:0]                    err_first
);

  localparam int CW = $clog2(OUTSTAND_MAX) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(OUTSTAND_MAX);

  typedef struct packed {
    logic                  aw_stall;
    logic                  w_stall;
    logic                  ar_stall;
    logic                  b_stall;
    logic                  r_stall;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic [1:0]            bresp;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
  } hist_t;

  logic          aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic          aw_zero, w_zero, ar_zero;
  logic [CW-1:0] aw_cnt_q, aw_cnt_d, w_cnt_q, w_cnt_d, ar_cnt_q, ar_cnt_d;
  hist_t         hist_q, hist_d;
  logic [11:0]   err_flags_q, err_flags_d, err_new, err_base, err_rise;
  logic          err_pulse_q, err_pulse_d;
  logic [3:0]    err_first_q, err_first_d;
  logic          b_timeout, r_timeout;

  function automatic logic [CW-1:0] step_cnt(input logic [CW-1:0] cnt, input logic inc,
                                             input logic dec);
    step_cnt = cnt;
    if (inc && !dec && cnt != CNT_MAX) step_cnt = cnt + CW'(1);
    else if (dec && !inc && cnt != '0) step_cnt = cnt - CW'(1);
  endfunction

  function automatic logic [3:0] lowest_bit(input logic [11:0] v);
    lowest_bit = 4'hF;
    for (int i = 11; i >= 0; i--) if (v[i]) lowest_bit = 4'(i);
  endfunction

  assign aw_hs   = m_axil_awvalid & m_axil_awready;
  assign w_hs    = m_axil_wvalid & m_axil_wready;
  assign b_hs    = m_axil_bvalid & m_axil_bready;
  assign ar_hs   = m_axil_arvalid & m_axil_arready;
  assign r_hs    = m_axil_rvalid & m_axil_rready;
  assign aw_zero = (aw_cnt_q == '0);
  assign w_zero  = (w_cnt_q == '0);
  assign ar_zero = (ar_cnt_q == '0);

  always_comb begin
    hist_d.aw_stall = m_axil_awvalid & ~m_axil_awready;
    hist_d.w_stall  = m_axil_wvalid & ~m_axil_wready;
    hist_d.ar_stall = m_axil_arvalid & ~m_axil_arready;
    hist_d.b_stall  = m_axil_bvalid & ~m_axil_bready;
    hist_d.r_stall  = m_axil_rvalid & ~m_axil_rready;
    hist_d.awaddr   = m_axil_awaddr;
    hist_d.awprot   = m_axil_awprot;
    hist_d.wdata    = m_axil_wdata;
    hist_d.wstrb    = m_axil_wstrb;
    hist_d.araddr   = m_axil_araddr;
    hist_d.arprot   = m_axil_arprot;
    hist_d.bresp    = m_axil_bresp;
    hist_d.rdata    = m_axil_rdata;
    hist_d.rresp    = m_axil_rresp;

    aw_cnt_d = step_cnt(aw_cnt_q, aw_hs, b_hs);
    w_cnt_d  = step_cnt(w_cnt_q, w_hs, b_hs);
    ar_cnt_d = step_cnt(ar_cnt_q, ar_hs, r_hs);

    // A stalled channel must keep valid asserted and its payload frozen.
    err_new     = '0;
    err_new[0]  = hist_q.aw_stall && (!m_axil_awvalid || m_axil_awaddr != hist_q.awaddr ||
                                      m_axil_awprot != hist_q.awprot);
    err_new[1]  = hist_q.w_stall && (!m_axil_wvalid || m_axil_wdata != hist_q.wdata ||
                                     m_axil_wstrb != hist_q.wstrb);
    err_new[2]  = hist_q.ar_stall && (!m_axil_arvalid || m_axil_araddr != hist_q.araddr ||
                                      m_axil_arprot != hist_q.arprot);
    err_new[3]  = hist_q.b_stall && (!m_axil_bvalid || m_axil_bresp != hist_q.bresp);
    err_new[4]  = hist_q.r_stall && (!m_axil_rvalid || m_axil_rdata != hist_q.rdata ||
                                     m_axil_rresp != hist_q.rresp);
    err_new[5]  = (b_hs && (aw_zero || w_zero)) ||
                  (m_axil_bvalid && ((aw_zero && !aw_hs) || (w_zero && !w_hs)));
    err_new[6]  = (r_hs && ar_zero) || (m_axil_rvalid && ar_zero && !ar_hs);
    err_new[7]  = aw_hs && !b_hs && aw_cnt_q == CNT_MAX;
    err_new[8]  = w_hs && !b_hs && w_cnt_q == CNT_MAX;
    err_new[9]  = ar_hs && !r_hs && ar_cnt_q == CNT_MAX;
    err_new[10] = b_timeout;
    err_new[11] = r_timeout;

    // A clear drops old flags, but anything detected in the same cycle is kept and recorded.
    err_base    = err_clear ? 12'h000 : err_flags_q;
    err_rise    = err_new & ~err_base;
    err_flags_d = err_base | err_new;
    err_pulse_d = |err_rise;
    err_first_d = err_clear ? 4'hF : err_first_q;
    if (err_base == 12'h000 && err_rise != 12'h000) err_first_d = lowest_bit(err_rise);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aw_cnt_q    <= '0;
      w_cnt_q     <= '0;
      ar_cnt_q    <= '0;
      hist_q      <= '0;
      err_flags_q <= '0;
      err_pulse_q <= 1'b0;
      err_first_q <= 4'hF;
    end else begin
      aw_cnt_q    <= aw_cnt_d;
      w_cnt_q     <= w_cnt_d;
      ar_cnt_q    <= ar_cnt_d;
      hist_q      <= hist_d;
      err_flags_q <= err_flags_d;
      err_pulse_q <= err_pulse_d;
      err_first_q <= err_first_d;
    end
  end

`ifdef F_AXIL_MONITOR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] b_timer_q, b_timer_d, r_timer_q, r_timer_d;

  // Timers flag once on reaching the limit, then hold there until the response arrives.
  always_comb begin
    b_timer_d = b_timer_q;
    r_timer_d = r_timer_q;
    b_timeout = 1'b0;
    r_timeout = 1'b0;
    if (b_hs || aw_zero || w_zero) b_timer_d = '0;
    else if (b_timer_q != T_MAX) begin
      b_timer_d = b_timer_q + TW'(1);
      b_timeout = (b_timer_d == T_MAX);
    end
    if (r_hs || ar_zero) r_timer_d = '0;
    else if (r_timer_q != T_MAX) begin
      r_timer_d = r_timer_q + TW'(1);
      r_timeout = (r_timer_d == T_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      b_timer_q <= '0;
      r_timer_q <= '0;
    end else begin
      b_timer_q <= b_timer_d;
      r_timer_q <= r_timer_d;
    end
  end
`else
  // TIMEOUT_CYCLES is meaningless in this build; the comparison is constant false.
  assign b_timeout = 1'b0;
  assign r_timeout = (TIMEOUT_CYCLES < 0);
`endif

  assign aw_cnt    = aw_cnt_q;
  assign w_cnt     = w_cnt_q;
  assign ar_cnt    = ar_cnt_q;
  assign err_flags = err_flags_q;
  assign err_pulse = err_pulse_q;
  assign err_first = err_first_q;

endmodule
